// File: rtl/dispatch_pkg.sv
// Shared types and sizing helpers for the instruction dispatch queue.
package dispatch_pkg;

    typedef enum logic {
        DISPATCH_BROADCAST   = 1'b0,
        DISPATCH_ROUND_ROBIN = 1'b1
    } dispatch_mode_t;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_DEPTH     = 32;
    localparam int DEFAULT_NUM_CORES = 4;

    // Occupancy spans 0..DEPTH+1: every queue entry plus the dispatch slot.
    function automatic int fill_count_width(input int depth);
        return $clog2(depth + 2);
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/circ_fifo_store.sv
// Circular instruction store: storage array, wrapping pointers, count and full/empty.
module circ_fifo_store #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable because
    // only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_dispatch_queue.sv
// Instruction queue feeding NUM_CORES cores through one registered dispatch slot,
// in broadcast (all cores accept) or round-robin (one core in rotation) mode.
module instr_dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    localparam int FILL_W   = fill_count_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 mode,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    input  logic [NUM_CORES-1:0] core_ready,
    output logic [NUM_CORES-1:0] out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [FILL_W-1:0]    fill_count,
    output logic                 overflow
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int RRW = index_width(NUM_CORES);

    dispatch_mode_t       mode_sel;
    dispatch_mode_t       slot_mode;
    logic [WIDTH-1:0]     slot_data;
    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] pending_kept;
    logic [NUM_CORES-1:0] rr_onehot;
    logic [RRW-1:0]       rr_ptr;
    logic [RRW-1:0]       rr_next;
    logic                 any_accept;
    logic                 slot_free;
    logic                 load;
    logic                 push;

    logic [WIDTH-1:0]     q_head;
    logic [CW-1:0]        q_count;
    logic                 q_full;
    logic                 q_empty;

    assign mode_sel = dispatch_mode_t'(mode);

    // in_ready comes from the registered count only, never from core_ready.
    assign in_ready = !q_full;
    assign push     = in_valid && in_ready && !flush;

    circ_fifo_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .pop     (load),
        .wr_data (in_data),
        .rd_data (q_head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    // A core that accepts drops out of the mask; the slot reloads on the same
    // edge its last pending core accepts, sustaining one instruction per cycle.
    always_comb begin
        pending_kept = pending & ~core_ready;
        any_accept   = |(pending & core_ready);
        slot_free    = (pending_kept == '0);
        load         = slot_free && !q_empty && !flush;
        rr_next      = rr_ptr;
        if (slot_mode == DISPATCH_ROUND_ROBIN && any_accept) begin
            rr_next = (rr_ptr == RRW'(NUM_CORES - 1)) ? '0 : rr_ptr + RRW'(1);
        end
    end

    // A reload after a round-robin accept targets the already-advanced pointer.
    always_comb begin
        rr_onehot = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            rr_onehot[i] = (rr_next == RRW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_data <= '0;
            slot_mode <= DISPATCH_BROADCAST;
            pending   <= '0;
            rr_ptr    <= '0;
            overflow  <= 1'b0;
        end else if (flush) begin
            slot_data <= '0;
            slot_mode <= DISPATCH_BROADCAST;
            pending   <= '0;
            rr_ptr    <= '0;
            overflow  <= 1'b0;
        end else begin
            rr_ptr <= rr_next;
            if (load) begin
                slot_data <= q_head;
                slot_mode <= mode_sel;
                pending   <= (mode_sel == DISPATCH_BROADCAST) ? '1 : rr_onehot;
            end else begin
                pending <= pending_kept;
            end
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

    assign out_valid  = pending;
    assign out_data   = slot_data;
    assign fill_count = FILL_W'(q_count) + FILL_W'(|pending);

endmodule

// File: tb/tb_instr_dispatch_queue.sv
// Randomised and directed scoreboard bench for instr_dispatch_queue.
module tb_instr_dispatch_queue;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 32;
    localparam int NUM_CORES = 4;
    localparam int FILL_W    = $clog2(DEPTH + 2);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 mode;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic [NUM_CORES-1:0] core_ready;
    logic [NUM_CORES-1:0] out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [FILL_W-1:0]    fill_count;
    logic                 overflow;

    instr_dispatch_queue #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .NUM_CORES (NUM_CORES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .core_ready (core_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fill_count (fill_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending instructions plus the set of
    // cores that still owe an accept on the instruction being offered.
    typedef struct {
        int               core;
        logic [WIDTH-1:0] data;
    } accept_t;

    accept_t              exp_q[$];
    logic [WIDTH-1:0]     m_q[$];
    logic [NUM_CORES-1:0] m_pending;
    logic [WIDTH-1:0]     m_data;
    logic                 m_rr_mode;
    int                   m_rr;
    logic                 m_over;

    logic [NUM_CORES-1:0] e_valid;
    logic [WIDTH-1:0]     e_data;
    logic                 e_ready;
    int                   e_fill;
    logic                 e_over;

    task automatic model_clear();
        m_q.delete();
        m_pending = '0;
        m_data    = '0;
        m_rr_mode = 1'b0;
        m_rr      = 0;
        m_over    = 1'b0;
    endtask

    task automatic model_step();
        bit      taken;
        bit      any;
        accept_t a;
        if (flush) begin
            model_clear();
            return;
        end
        taken = in_valid && (m_q.size() < DEPTH);
        if (in_valid && !taken) m_over = 1'b1;
        any = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (m_pending[i] && core_ready[i]) begin
                a.core = i;
                a.data = m_data;
                exp_q.push_back(a);
                m_pending[i] = 1'b0;
                any = 1;
            end
        end
        if (any && m_rr_mode) m_rr = (m_rr + 1) % NUM_CORES;
        if (m_pending == '0 && m_q.size() > 0) begin
            m_data    = m_q.pop_front();
            m_rr_mode = mode;
            m_pending = '0;
            if (!mode) m_pending = '1;
            else       m_pending[m_rr] = 1'b1;
        end
        if (taken) m_q.push_back(in_data);
    endtask

    // Model: inputs for the coming edge are stable 1 time unit after the negedge.
    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            #1;
            if (!reset) model_clear();
            e_valid = m_pending;
            e_data  = m_data;
            e_ready = (m_q.size() != DEPTH);
            e_fill  = m_q.size() + ((m_pending != '0) ? 1 : 0);
            e_over  = m_over;
            if (reset) model_step();
        end
    end

    // Monitor: compares DUT state and pops one expectation per observed accept.
    initial begin
        accept_t a;
        forever begin
            @(negedge clk);
            #2;
            check("out_valid", 64'(out_valid), 64'(e_valid));
            check("out_data", 64'(out_data), 64'(e_data));
            check("in_ready", 64'(in_ready), 64'(e_ready));
            check("fill_count", 64'(fill_count), 64'(e_fill));
            check("overflow", 64'(overflow), 64'(e_over));
            if (reset && !flush) begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (out_valid[i] && core_ready[i]) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_accept_core", 64'(i), 64'hFFFF_FFFF);
                        end else begin
                            a = exp_q.pop_front();
                            check("accept_core", 64'(i), 64'(a.core));
                            check("accept_data", 64'(out_data), 64'(a.data));
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d,
                       input logic [NUM_CORES-1:0] rdy, input logic md, input logic fl);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        core_ready = rdy;
        mode       = md;
        flush      = fl;
    endtask

    task automatic idle(input int n, input logic [NUM_CORES-1:0] rdy, input logic md);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy, md, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        mode       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        core_ready = '0;
        idle(3, '0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Broadcast: split accepts, second instruction waits for all four.
        cyc(1'b1, 32'hA5A5_0001, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 32'hA5A5_0002, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, '0, 4'b0101, 1'b0, 1'b0);
        cyc(1'b0, '0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b0, '0, 4'b1010, 1'b0, 1'b0);
        idle(2, 4'b0000, 1'b0);
        idle(3, 4'b1111, 1'b0);

        // Round-robin, back-to-back, all cores ready; all-zero data is ordinary.
        for (int k = 0; k < 8; k++) cyc(1'b1, 32'h10 + k, 4'b1111, 1'b1, 1'b0);
        cyc(1'b1, 32'h0, 4'b1111, 1'b1, 1'b0);
        idle(4, 4'b1111, 1'b1);

        // Fill queue and slot with cores stalled, then overflow.
        for (int k = 0; k < DEPTH + 1; k++) cyc(1'b1, 32'h100 + k, 4'b0000, 1'b1, 1'b0);
        idle(2, 4'b0000, 1'b1);
        cyc(1'b1, 32'hDEAD, 4'b0000, 1'b1, 1'b0);
        idle(2, 4'b0000, 1'b1);
        cyc(1'b0, '0, NUM_CORES'(1) << m_rr, 1'b1, 1'b0);
        idle(2, 4'b0000, 1'b1);
        idle(DEPTH + 4, 4'b1111, 1'b1);

        // Round-robin with core1 stalled, starting from a flushed pointer.
        cyc(1'b0, '0, 4'b0000, 1'b1, 1'b1);
        cyc(1'b1, 32'h20, 4'b1101, 1'b1, 1'b0);
        cyc(1'b1, 32'h21, 4'b1101, 1'b1, 1'b0);
        cyc(1'b1, 32'h22, 4'b1101, 1'b1, 1'b0);
        idle(4, 4'b1101, 1'b1);
        idle(4, 4'b1111, 1'b1);

        // Flush coinciding with a push and an accept, 3 queued behind the slot.
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'h30 + k, 4'b0000, 1'b0, 1'b0);
        idle(1, 4'b0000, 1'b0);
        cyc(1'b1, 32'h3F, 4'b1111, 1'b0, 1'b1);
        cyc(1'b1, 32'h55, 4'b1111, 1'b1, 1'b0);
        idle(3, 4'b1111, 1'b1);

        // Asynchronous reset mid-stream with 5 queued behind the slot.
        for (int k = 0; k < 6; k++) cyc(1'b1, 32'h40 + k, 4'b0000, 1'b1, 1'b0);
        idle(1, 4'b0000, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        idle(2, 4'b0000, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h50 + k, 4'b1111, 1'b1, 1'b0);
        idle(3, 4'b1111, 1'b1);

        // Random traffic with occasional mode changes, flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            logic md;
            md = mode;
            if ($urandom_range(0, 15) == 0) md = ~mode;
            cyc(1'($urandom_range(0, 1)), $urandom,
                NUM_CORES'($urandom) | NUM_CORES'($urandom),
                md, ($urandom_range(0, 99) == 0));
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                idle(1, '0, mode);
                @(negedge clk);
                reset = 1'b1;
            end
        end

        idle(DEPTH + 10, 4'b1111, 1'b0);
        @(negedge clk);
        #3;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
